// File: rtl/uart_rx_if.sv
// Receiver-side bundle for the 8N1 serial line: the raw line in, plus the
// received byte, its strobes and the busy flag out.
interface uart_rx_if;
    logic       rx;
    logic [7:0] data;
    logic       valid;
    logic       frame_err;
    logic       busy;

    modport master (output rx, input data, input valid, input frame_err, input busy);
    modport slave  (input rx, output data, output valid, output frame_err, output busy);
endinterface

// File: rtl/uart_rx.sv
// 8N1 UART receiver: 2-flop synchroniser, mid-bit sampling, framing-error and false-start detection.
// Optional UART_RX_MAJORITY_EN: every sample point takes the majority of the last three synchronised values.
module uart_rx #(
    parameter int CLK_FREQ = 125_000_000,
    parameter int BAUD     = 9600
) (
    input  logic      clk,
    input  logic      rst_n,
    uart_rx_if.slave  bus
);
    localparam int          DIV       = CLK_FREQ / BAUD;
    localparam logic [31:0] DIV_LAST  = 32'(DIV - 1);
    localparam logic [31:0] HALF_LAST = 32'(DIV / 2 - 1);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_e;

    state_e      state_q, state_d;
    logic [31:0] baud_q, baud_d;
    logic [2:0]  bit_q, bit_d;
    logic [7:0]  shift_q, shift_d;
    logic [7:0]  data_q, data_d;
    logic        valid_q, valid_d;
    logic        ferr_q, ferr_d;
    logic        sync1_q, rx_s_q, rx_d_q;
    logic        sample;

`ifdef UART_RX_MAJORITY_EN
    // Two older values plus the current rx_s form the three-sample vote window.
    logic [1:0] hist_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) hist_q <= 2'b11;
        else        hist_q <= {hist_q[0], rx_s_q};
    end

    assign sample = (hist_q[1] & hist_q[0]) | (hist_q[1] & rx_s_q) | (hist_q[0] & rx_s_q);
`else
    assign sample = rx_s_q;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= 1'b1;
            rx_s_q  <= 1'b1;
            rx_d_q  <= 1'b1;
            state_q <= IDLE;
            baud_q  <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
        end else begin
            sync1_q <= bus.rx;
            rx_s_q  <= sync1_q;
            rx_d_q  <= rx_s_q;
            state_q <= state_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            ferr_q  <= ferr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        baud_d  = baud_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        data_d  = data_q;
        valid_d = 1'b0;
        ferr_d  = 1'b0;
        case (state_q)
            IDLE: begin
                baud_d = '0;
                if (rx_d_q && !rx_s_q) state_d = START;
            end
            START: begin
                if (baud_q == HALF_LAST) begin
                    baud_d = '0;
                    if (sample) begin
                        state_d = IDLE;
                    end else begin
                        state_d = DATA;
                        bit_d   = '0;
                    end
                end else begin
                    baud_d = baud_q + 32'd1;
                end
            end
            DATA: begin
                if (baud_q == DIV_LAST) begin
                    baud_d         = '0;
                    shift_d[bit_q] = sample;
                    if (bit_q == 3'd7) state_d = STOP;
                    else               bit_d   = bit_q + 3'd1;
                end else begin
                    baud_d = baud_q + 32'd1;
                end
            end
            STOP: begin
                // Return to IDLE at mid-stop-bit so an immediately following start edge is seen.
                if (baud_q == DIV_LAST) begin
                    baud_d  = '0;
                    state_d = IDLE;
                    if (sample) begin
                        data_d  = shift_q;
                        valid_d = 1'b1;
                    end else begin
                        ferr_d  = 1'b1;
                    end
                end else begin
                    baud_d = baud_q + 32'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        bus.busy      = (state_q != IDLE);
        bus.data      = data_q;
        bus.valid     = valid_q;
        bus.frame_err = ferr_q;
    end
endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx at DIV=16: good frames, framing error, false start,
// back-to-back frames, break, mid-frame reset and a mid-bit glitch.
module tb_uart_rx;
    localparam int CLK_FREQ = 160;
    localparam int BAUD     = 10;
    localparam int DIV      = 16;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    uart_rx_if bus ();

    uart_rx #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_vec  = 0;
    int n_miss = 0;

    int         cyc            = 0;
    int         n_valid        = 0;
    int         n_ferr         = 0;
    int         n_both         = 0;
    int         n_wide         = 0;
    int         busy_after_bad = 0;
    int         last_valid_cyc = 0;
    logic [7:0] last_vdata     = 8'h00;
    logic       prev_valid     = 1'b0;
    logic       prev_ferr      = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (bus.valid) begin
            n_valid        <= n_valid + 1;
            last_valid_cyc <= cyc;
            last_vdata     <= bus.data;
        end
        if (bus.frame_err)                                          n_ferr <= n_ferr + 1;
        if (bus.valid && bus.frame_err)                             n_both <= n_both + 1;
        if ((bus.valid && prev_valid) || (bus.frame_err && prev_ferr)) n_wide <= n_wide + 1;
        if (prev_valid && bus.busy)                                 busy_after_bad <= busy_after_bad + 1;
        prev_valid <= bus.valid;
        prev_ferr  <= bus.frame_err;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic send_bit(input logic b, input logic glitch);
        bus.rx = b;
        if (glitch) begin
            repeat (DIV / 2) @(negedge clk);
            bus.rx = ~b;
            @(negedge clk);
            bus.rx = b;
            repeat (DIV / 2 - 1) @(negedge clk);
        end else begin
            repeat (DIV) @(negedge clk);
        end
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop, input int gbit);
        send_bit(1'b0, 1'b0);
        for (int i = 0; i < 8; i++) send_bit(d[i], (i == gbit));
        send_bit(stop, 1'b0);
    endtask

    int         v0, f0, t0, c1, lat, gap;
    logic [7:0] d1, exp_glitch;

    initial begin
        bus.rx = 1'b1;
        rst_n  = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_data",  bus.data,      32'h00);
        chk("rst_valid", bus.valid,     32'h0);
        chk("rst_ferr",  bus.frame_err, 32'h0);
        chk("rst_busy",  bus.busy,      32'h0);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);

        // good frame 0xA5
        v0 = n_valid; f0 = n_ferr; t0 = cyc;
        send_frame(8'hA5, 1'b1, -1);
        lat = last_valid_cyc - t0;
        chk("a5_vcnt",  n_valid - v0, 1);
        chk("a5_data",  bus.data, 32'hA5);
        chk("a5_vdata", last_vdata, 32'hA5);
        chk("a5_ferr",  n_ferr - f0, 0);
        chk("a5_lat",   (lat >= 153 && lat <= 157), 1);
        chk("a5_busy",  bus.busy, 0);
        repeat (5) @(negedge clk);

        // stop bit low -> framing error, data held
        v0 = n_valid; f0 = n_ferr;
        send_frame(8'h3C, 1'b0, -1);
        bus.rx = 1'b1;
        repeat (4) @(negedge clk);
        chk("fe_ferr",  n_ferr - f0, 1);
        chk("fe_vcnt",  n_valid - v0, 0);
        chk("fe_data",  bus.data, 32'hA5);
        repeat (5) @(negedge clk);

        // false start
        v0 = n_valid; f0 = n_ferr;
        bus.rx = 1'b0;
        repeat (4) @(negedge clk);
        chk("fs_busy_hi", bus.busy, 1);
        bus.rx = 1'b1;
        repeat (20) @(negedge clk);
        chk("fs_busy_lo", bus.busy, 0);
        chk("fs_vcnt",    n_valid - v0, 0);
        chk("fs_ferr",    n_ferr - f0, 0);

        // back-to-back 0x00 then 0xFF
        v0 = n_valid;
        send_frame(8'h00, 1'b1, -1);
        c1 = last_valid_cyc; d1 = last_vdata;
        send_frame(8'hFF, 1'b1, -1);
        gap = last_valid_cyc - c1;
        chk("bb_vcnt", n_valid - v0, 2);
        chk("bb_d1",   d1, 32'h00);
        chk("bb_d2",   last_vdata, 32'hFF);
        chk("bb_gap",  (gap >= 159 && gap <= 161), 1);
        repeat (5) @(negedge clk);

        // break: line stays low after a frame
        v0 = n_valid; f0 = n_ferr;
        send_frame(8'h00, 1'b0, -1);
        repeat (3 * DIV) @(negedge clk);
        chk("brk_ferr", n_ferr - f0, 1);
        chk("brk_vcnt", n_valid - v0, 0);
        chk("brk_busy", bus.busy, 0);
        bus.rx = 1'b1;
        repeat (20) @(negedge clk);

        // reset during bit 4 of 0x5A, then 0x81
        v0 = n_valid;
        send_bit(1'b0, 1'b0);
        for (int i = 0; i < 4; i++) send_bit(logic'((8'h5A >> i) & 8'h01), 1'b0);
        bus.rx = 1'b1;
        repeat (DIV / 2) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("mr_data_rst", bus.data, 32'h00);
        chk("mr_busy_rst", bus.busy, 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        chk("mr_data", bus.data, 32'h00);
        send_frame(8'h81, 1'b1, -1);
        repeat (4) @(negedge clk);
        chk("mr_vcnt", n_valid - v0, 1);
        chk("mr_d81",  bus.data, 32'h81);
        repeat (5) @(negedge clk);

        // glitch at mid-bit of bit 2
`ifdef UART_RX_MAJORITY_EN
        exp_glitch = 8'h55;
`else
        exp_glitch = 8'h51;
`endif
        v0 = n_valid;
        send_frame(8'h55, 1'b1, 2);
        repeat (4) @(negedge clk);
        chk("gl_vcnt", n_valid - v0, 1);
        chk("gl_data", bus.data, exp_glitch);

        chk("pulse_overlap", n_both, 0);
        chk("pulse_width",   n_wide, 0);
        chk("busy_after_v",  busy_after_bad, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end
endmodule
